mdio_slave: RTL and testbench

- Clause 22 MDIO responder (PHY-side) for the same bus our AXI MDIO master drives; lets FPGA logic present emulated PHY/management registers to an external or in-fabric MDIO master.
- Oversamples MDC/MDIO on the system clock, decodes frames addressed to C_PHY_ADDR, issues single-cycle register read/write strobes, and drives read data back through an external tristate buffer (mdio_i/mdio_o/mdio_t).

---
 rtl/mdio_slave.sv | 186 ++++++++++++++++++
 tb/tb_mdio_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder (PHY side).
// Oversamples MDC/MDIO on clk, decodes frames addressed to C_PHY_ADDR, issues
// single-cycle register strobes and returns read data through an external tristate.
module mdio_slave #(
  parameter logic [4:0]  C_PHY_ADDR     = 5'd0,
  parameter int unsigned C_PREAMBLE_MIN = 32,
  parameter int unsigned C_SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  localparam logic [5:0] PreMin = 6'(C_PREAMBLE_MIN);

  typedef enum logic [2:0] {
    StIdle, StSt2, StOp, StPhy, StReg, StTa, StData
  } state_e;

  logic [C_SYNC_STAGES-1:0] mdc_sync;
  logic [C_SYNC_STAGES-1:0] mdio_sync;
  logic                     mdc_prev;
  logic                     bit_ev;
  logic                     smp;

  state_e      state;
  logic [3:0]  cnt;
  logic [5:0]  pre_cnt;
  logic        op_hi;
  logic        is_read;
  logic        match;
  logic [15:0] sr;

  // Synchronize the asynchronous MDC/MDIO inputs into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '1;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[C_SYNC_STAGES-2:0], mdc};
      mdio_sync <= {mdio_sync[C_SYNC_STAGES-2:0], mdio_i};
      mdc_prev  <= mdc_sync[C_SYNC_STAGES-1];
    end
  end

  assign bit_ev = mdc_sync[C_SYNC_STAGES-1] & ~mdc_prev;
  assign smp    = mdio_sync[C_SYNC_STAGES-1];

  // Frame decoder FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      pre_cnt   <= '0;
      op_hi     <= 1'b0;
      is_read   <= 1'b0;
      match     <= 1'b0;
      sr        <= '0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      // Read data arrives the cycle after the read strobe.
      if (reg_rd) sr <= reg_rdata;
      if (bit_ev) begin
        case (state)
          StIdle: begin
            if (smp) begin
              if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              if (pre_cnt >= PreMin) begin
                state <= StSt2;
                busy  <= 1'b1;
              end
              pre_cnt <= '0;
            end
          end
          StSt2: begin
            if (smp) begin
              state <= StOp;
              cnt   <= '0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
          StOp: begin
            if (cnt == 4'd0) begin
              op_hi <= smp;
              cnt   <= 4'd1;
            end else if (op_hi != smp) begin
              is_read <= op_hi;
              state   <= StPhy;
              cnt     <= '0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
          StPhy: begin
            sr <= {sr[14:0], smp};
            if (cnt == 4'd4) begin
              match <= ({sr[3:0], smp} == C_PHY_ADDR);
              state <= StReg;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          StReg: begin
            reg_addr <= {reg_addr[3:0], smp};
            if (cnt == 4'd4) begin
              if (is_read && match) reg_rd <= 1'b1;
              state <= StTa;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          StTa: begin
            if (cnt == 4'd0) begin
              if (!is_read && !smp) begin
                state <= StIdle;
                busy  <= 1'b0;
              end else begin
                if (is_read && match) begin
                  mdio_t <= 1'b0;
                  mdio_o <= 1'b0;
                end
                cnt <= 4'd1;
              end
            end else if (!is_read && smp) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              // Present rdata[15] so the master sees it at the first data edge.
              if (is_read && match) begin
                mdio_o <= sr[15];
                sr     <= {sr[14:0], 1'b0};
              end
              state <= StData;
              cnt   <= '0;
            end
          end
          StData: begin
            sr <= {sr[14:0], smp};
            if (is_read && match) mdio_o <= sr[15];
            if (cnt == 4'd15) begin
              mdio_t <= 1'b1;
              mdio_o <= 1'b1;
              state  <= StIdle;
              busy   <= 1'b0;
              if (!is_read && match) begin
                reg_wdata <= {sr[14:0], smp};
                reg_wr    <= 1'b1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: bit-banged MDIO master, register-side scoreboard.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        busy;

  logic master_en = 1'b1;
  logic mdio_m = 1'b1;
  logic mdio_line;
  logic win = 1'b0;
  logic busy_seen = 1'b0;

  int total = 0;
  int bad = 0;

  logic [4:0]  rd_q[$];
  logic [20:0] wr_q[$];
  logic [15:0] rdat_q[$];

  mdio_slave #(
    .C_PHY_ADDR(5'd5),
    .C_PREAMBLE_MIN(32),
    .C_SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mdc(mdc),
    .mdio_i(mdio_i),
    .mdio_o(mdio_o),
    .mdio_t(mdio_t),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr(reg_wr),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Bus with pull-up: responder wins when driving, else master, else high.
  assign mdio_line = !mdio_t ? mdio_o : (master_en ? mdio_m : 1'b1);
  assign mdio_i    = mdio_line;

  function automatic logic [15:0] rmem(input logic [4:0] a);
    return (a == 5'd3) ? 16'hBEEF : {a, 11'h4C3};
  endfunction

  // Register file answers only while the read strobe is up.
  assign reg_rdata = reg_rd ? rmem(reg_addr) : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor pops the scoreboard; also polices line driving.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (reg_rd) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(reg_rd), 32'd0);
        else check("rd_addr", 32'(reg_addr), 32'(rd_q.pop_front()));
      end
      if (reg_wr) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'(reg_wr), 32'd0);
        else begin
          logic [20:0] e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(e[20:16]));
          check("wr_data", 32'(reg_wdata), 32'(e[15:0]));
        end
      end
      if (!mdio_t && (!win || master_en)) check("drive_window", 32'(mdio_t), 32'd1);
    end
  end

  task automatic send_bit(input logic b);
    mdio_m = b;
    #40 mdc = 1'b1;
    #40 mdc = 1'b0;
  endtask

  task automatic rx_bit(output logic b);
    #40 b = mdio_line;
    mdc = 1'b1;
    #40 mdc = 1'b0;
  endtask

  // rx = {TA1, TA2, data[15:0]} as sampled by the master on released frames.
  task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                       input logic [15:0] wd, input bit rel, input bit drive_ok,
                       input int ndata, output logic [17:0] rx);
    logic b;
    rx = '0;
    busy_seen = 1'b0;
    master_en = 1'b1;
    repeat (pre) send_bit(1'b1);
    for (int i = 1; i >= 0; i--) send_bit(st[i]);
    for (int i = 1; i >= 0; i--) send_bit(op[i]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    if (rel) begin
      master_en = 1'b0;
      win = drive_ok;
      for (int i = 0; i < 2 + ndata; i++) begin
        rx_bit(b);
        rx = {rx[16:0], b};
      end
    end else begin
      for (int i = 1; i >= 0; i--) send_bit(ta[i]);
      for (int i = 15; i >= 16 - ndata; i--) send_bit(wd[i]);
    end
    if (ndata == 16) begin
      master_en = 1'b1;
      win = 1'b0;
      mdio_m = 1'b1;
      #100;
    end
  endtask

  task automatic good_read(input logic [4:0] ra, input string tag);
    logic [17:0] rx;
    rd_q.push_back(ra);
    rdat_q.push_back(rmem(ra));
    frame(32, 2'b01, 2'b10, 5'd5, ra, 2'b00, 16'h0, 1'b1, 1'b1, 16, rx);
    check({tag, "_ta1"}, 32'(rx[17]), 32'd1);
    check({tag, "_ta2"}, 32'(rx[16]), 32'd0);
    check({tag, "_data"}, 32'(rx[15:0]), 32'(rdat_q.pop_front()));
    check({tag, "_released"}, 32'(mdio_t), 32'd1);
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic good_write(input logic [4:0] ra, input logic [15:0] wd, input string tag);
    logic [17:0] rx;
    wr_q.push_back({ra, wd});
    frame(32, 2'b01, 2'b01, 5'd5, ra, 2'b10, wd, 1'b0, 1'b0, 16, rx);
    check({tag, "_hold_addr"}, 32'(reg_addr), 32'(ra));
    check({tag, "_hold_data"}, 32'(reg_wdata), 32'(wd));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] rx;
    #20;
    check("rst_mdio_t", 32'(mdio_t), 32'd1);
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_rd", 32'(reg_rd), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    #30 rst_n = 1'b1;
    #100;

    good_read(5'd3, "read3");
    good_write(5'd31, 16'h1234, "write31");

    // Frames to another PHY: tracked but ignored, line never driven.
    frame(32, 2'b01, 2'b10, 5'd6, 5'd3, 2'b00, 16'h0, 1'b1, 1'b0, 16, rx);
    check("miss_rd_ta2", 32'(rx[16]), 32'd1);
    check("miss_rd_data", 32'(rx[15:0]), 32'hFFFF);
    frame(32, 2'b01, 2'b01, 5'd6, 5'd7, 2'b10, 16'hFFFF, 1'b0, 1'b0, 16, rx);
    check("miss_wr_hold", 32'(reg_wdata), 32'h1234);
    good_read(5'd10, "read10");

    // One preamble bit short: never leaves idle.
    frame(31, 2'b01, 2'b01, 5'd5, 5'd2, 2'b10, 16'h5555, 1'b0, 1'b0, 16, rx);
    check("short_pre_busy", 32'(busy_seen), 32'd0);
    good_write(5'd2, 16'h5555, "full_pre");

    // Malformed frames abort without strobes.
    frame(32, 2'b00, 2'b01, 5'd5, 5'd4, 2'b10, 16'h0, 1'b0, 1'b0, 16, rx);
    check("err_st_busy", 32'(busy), 32'd0);
    frame(32, 2'b01, 2'b11, 5'd5, 5'd4, 2'b10, 16'h0, 1'b0, 1'b0, 16, rx);
    check("err_op_busy", 32'(busy), 32'd0);
    frame(32, 2'b01, 2'b01, 5'd5, 5'd4, 2'b11, 16'h0, 1'b0, 1'b0, 16, rx);
    check("err_ta_busy", 32'(busy), 32'd0);
    check("err_ta_hold", 32'(reg_wdata), 32'h5555);
    good_read(5'd17, "after_err");

    // Reset in the middle of a driven read releases the line at once.
    rd_q.push_back(5'd3);
    frame(32, 2'b01, 2'b10, 5'd5, 5'd3, 2'b00, 16'h0, 1'b1, 1'b1, 4, rx);
    check("mid_rd_nibble", 32'(rx[3:0]), 32'hB);
    check("mid_rd_driving", 32'(mdio_t), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_t", 32'(mdio_t), 32'd1);
    check("async_rst_o", 32'(mdio_o), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    #50 rst_n = 1'b1;
    master_en = 1'b1;
    win = 1'b0;
    mdio_m = 1'b1;
    #100;
    good_write(5'd9, 16'hA5C3, "post_rst");
    good_read(5'd3, "post_rst_rd");

    #200;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
